// File: rtl/div_seq_ctrl.sv
// Sequencer for an iterative 32-bit signed divider. Restoring division runs on
// operand magnitudes, one quotient bit per cycle, and the sign is fixed up at the end.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, r_q, r_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, dz_q, dz_d, exc_q, exc_d;
  logic [WIDTH:0]   shifted, trial;

  // The magnitude of the most negative value (0x80..0) is kept as an unsigned pattern.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? ({WIDTH{1'b0}} - mag) : mag;
  endfunction

  // R stays below D (at most 2^(W-1)), so R[W-1] is always zero and may be dropped.
  assign shifted = {1'b0, r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (ctrl_div) begin
          q_d   = magnitude(data_operandA);
          d_d   = magnitude(data_operandB);
          r_d   = '0;
          cnt_d = '0;
          neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d  = (data_operandB == '0);
          // A zero divisor skips the iterations but still spends one edge in FIX.
          state_d = (data_operandB == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        r_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        res_d   = dz_q ? '0 : apply_sign(q_q, neg_q);
        exc_d   = dz_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, hand-written
// corner sequences, and random operands against a plain-arithmetic reference.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_div;
  logic [W-1:0] data_operandA, data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;

  int total = 0;
  int bad   = 0;

  div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ctrl_div(ctrl_div),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: signed division in 64-bit arithmetic truncates toward zero,
  // and keeping the low 32 bits yields the wrapping overflow case.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic exc);
    longint sa, sb, qq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      res = '0;
      exc = 1'b1;
    end else begin
      qq  = sa / sb;
      res = qq[W-1:0];
      exc = 1'b0;
    end
  endtask

  // Starts one division, waits (bounded) for the ready pulse, reports edges after E0.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic exc, output int lat);
    lat = 0;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    res = data_result;
    exc = data_exception;
    @(posedge clock);
    #1;
    check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("result_held", data_result, res);
  endtask

  logic [W-1:0] r, er;
  logic         x, ex;
  int           lat, rdy_seen;

  initial begin
    vecs[0]  = '{32'd100,       32'd7,          32'd14,         1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   1'b0, 33};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         1'b0, 33};
    vecs[4]  = '{32'd5,         32'd0,          32'd0,          1'b1, 1};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b0, 33};
    vecs[6]  = '{32'h80000000,  32'd2,          32'hC0000000,   1'b0, 33};
    vecs[7]  = '{32'd7,         32'd2,          32'd3,          1'b0, 33};
    vecs[8]  = '{32'd0,         32'd5,          32'd0,          1'b0, 33};
    vecs[9]  = '{32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   1'b0, 33};
    vecs[10] = '{32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 33};
    vecs[11] = '{32'h80000000,  32'h80000000,   32'd1,          1'b0, 33};

    reset = 1'b1;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].a, vecs[i].b, r, x, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_exc", i), {31'd0, x}, {31'd0, vecs[i].exc});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Starts during ITER and during the DONE cycle must be ignored.
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    lat = 0;
    for (int i = 7; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    check("ignore_latency", lat, 33);
    check("ignore_result", data_result, 32'd100);
    ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    check("done_start_busy", {31'd0, busy}, 32'd0);
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) rdy_seen++;
    end
    check("no_queued_op", rdy_seen, 0);
    check("ignore_result_held", data_result, 32'd100);
    run_div(32'd9, 32'd3, r, x, lat);
    check("after_ignore_result", r, 32'd3);
    check("after_ignore_latency", lat, 33);

    // Asynchronous reset in the middle of an operation.
    @(negedge clock);
    data_operandA = 32'hFFFFFFFF;
    data_operandB = 32'd1;
    ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", {31'd0, data_exception}, 32'd0);
    check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_div(32'd7, 32'd2, r, x, lat);
    check("post_rst_result", r, 32'd3);
    check("post_rst_exc", {31'd0, x}, 32'd0);
    check("post_rst_latency", lat, 33);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(15, 0);
        2: b = {{16{a[0]}}, 16'($urandom)};
        default: b = (i % 8 == 3) ? 32'd0 : 32'($urandom_range(1000, 1));
      endcase
      model(a, b, er, ex);
      run_div(a, b, r, x, lat);
      check($sformatf("rand%0d_result a=%h b=%h", i, a, b), r, er);
      check($sformatf("rand%0d_exc", i), {31'd0, x}, {31'd0, ex});
      check($sformatf("rand%0d_latency", i), lat, ex ? 1 : 33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
